// File: rtl/output_feature_map_streamer_pkg.sv
// Shared types and dimension helpers for the output feature-map streamer
// and the next layer's input buffer.
package output_feature_map_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_e;

    // Frame dimension including the zero-padding border on both sides.
    function automatic int padded_dim(input int dim, input int pad);
        return dim + 2 * pad;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/output_feature_map_streamer_if.sv
// Activation stream bundle: result pixels in from the compute array and
// padded stream elements out toward the next layer's input buffer.
interface output_feature_map_streamer_if #(
    parameter int ch = 128
);
    logic [ch-1:0] pix_in;
    logic          pix_in_valid;
    logic          pix_in_ready;
    logic [ch-1:0] stream_act;
    logic          stream_act_en;

    modport master (
        output pix_in,
        output pix_in_valid,
        input  pix_in_ready,
        input  stream_act,
        input  stream_act_en
    );

    modport slave (
        input  pix_in,
        input  pix_in_valid,
        output pix_in_ready,
        output stream_act,
        output stream_act_en
    );
endinterface

// File: rtl/output_feature_map_streamer_frame_position_counter.sv
// Raster row/col counter over the padded frame. Flags whether the current
// position lies in the padding border and whether it is the final position.
module frame_position_counter
    import output_feature_map_streamer_pkg::*;
#(
    parameter int w_pad = 34,
    parameter int h_pad = 34,
    parameter int pad   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic is_pad,
    output logic last
);
    localparam int COL_W = cnt_width(w_pad);
    localparam int ROW_W = cnt_width(h_pad);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(w_pad - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(h_pad - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // Position register: cleared at frame start, one raster step per advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (clear) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (advance) begin
            if (col_r == COL_LAST) begin
                col_r <= {COL_W{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_r <= {ROW_W{1'b0}};
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Border classification and end-of-frame detection for the current position.
    always_comb begin
        is_pad = 1'b0;
        last   = 1'b0;
        if ((int'(row_r) < pad) || (int'(row_r) >= h_pad - pad) ||
            (int'(col_r) < pad) || (int'(col_r) >= w_pad - pad)) begin
            is_pad = 1'b1;
        end else begin
            is_pad = 1'b0;
        end
        if ((row_r == ROW_LAST) && (col_r == COL_LAST)) begin
            last = 1'b1;
        end else begin
            last = 1'b0;
        end
    end

endmodule

// File: rtl/output_feature_map_streamer.sv
// Serialises one layer's output pixels into the activation stream and
// inserts the zero-padding border so each frame carries the full padded
// raster. Pad positions never wait on input; data positions wait for a pixel.
module output_feature_map_streamer
    import output_feature_map_streamer_pkg::*;
#(
    parameter int ch      = 128,
    parameter int w_out   = 32,
    parameter int h_out   = 32,
    parameter int pad     = 1,
    parameter bit pad_bit = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_start,
    output_feature_map_streamer_if.slave act_bus,
    output logic busy,
    output logic frame_done
);
    localparam int W_PAD = padded_dim(w_out, pad);
    localparam int H_PAD = padded_dim(h_out, pad);

    stream_state_e state_r;
    stream_state_e state_s;

    logic          advance_s;
    logic          clear_s;
    logic          ready_s;
    logic          is_pad_s;
    logic          last_s;
    logic [ch-1:0] act_r;
    logic          act_en_r;
    logic          busy_r;
    logic          frame_done_r;

    frame_position_counter #(
        .w_pad (W_PAD),
        .h_pad (H_PAD),
        .pad   (pad)
    ) u_position (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .advance (advance_s),
        .is_pad  (is_pad_s),
        .last    (last_s)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, raster advance and input handshake.
    always_comb begin
        state_s   = state_r;
        advance_s = 1'b0;
        clear_s   = 1'b0;
        ready_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (frame_start) begin
                    state_s = STREAM;
                    clear_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (is_pad_s) begin
                    advance_s = 1'b1;
                end else begin
                    ready_s   = 1'b1;
                    advance_s = act_bus.pix_in_valid;
                end
                if (advance_s && last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = STREAM;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output register: one element per advance, value held while idle or stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_r        <= {ch{1'b0}};
            act_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            act_en_r     <= advance_s;
            busy_r       <= (state_s != IDLE);
            frame_done_r <= (state_r == DONE);
            if (advance_s) begin
                act_r <= is_pad_s ? {ch{pad_bit}} : act_bus.pix_in;
            end else begin
                act_r <= act_r;
            end
        end
    end

    assign act_bus.pix_in_ready  = ready_s;
    assign act_bus.stream_act    = act_r;
    assign act_bus.stream_act_en = act_en_r;
    assign busy                  = busy_r;
    assign frame_done            = frame_done_r;

endmodule

// File: tb/tb_output_feature_map_streamer.sv
// Randomised bench for the output feature-map streamer. Three instances
// (pad=1/pad_bit=0, pad=1/pad_bit=1, pad=0) on a 4x3 frame with 4-bit pixels.
module tb_output_feature_map_streamer;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk;
    logic       reset;
    logic       fs_v     [3];
    logic [3:0] pix_v    [3];
    logic       valid_v  [3];
    logic [3:0] act_w    [3];
    logic       en_w     [3];
    logic       ready_w  [3];
    logic       busy_w   [3];
    logic       done_w   [3];

    int n_total = 0;
    int n_bad   = 0;

    output_feature_map_streamer_if #(.ch(4)) bus_a ();
    output_feature_map_streamer_if #(.ch(4)) bus_b ();
    output_feature_map_streamer_if #(.ch(4)) bus_c ();

    output_feature_map_streamer #(.ch(4), .w_out(W), .h_out(H), .pad(1), .pad_bit(1'b0)) dut_a (
        .clk(clk), .reset(reset), .frame_start(fs_v[0]), .act_bus(bus_a),
        .busy(busy_w[0]), .frame_done(done_w[0]));
    output_feature_map_streamer #(.ch(4), .w_out(W), .h_out(H), .pad(1), .pad_bit(1'b1)) dut_b (
        .clk(clk), .reset(reset), .frame_start(fs_v[1]), .act_bus(bus_b),
        .busy(busy_w[1]), .frame_done(done_w[1]));
    output_feature_map_streamer #(.ch(4), .w_out(W), .h_out(H), .pad(0), .pad_bit(1'b0)) dut_c (
        .clk(clk), .reset(reset), .frame_start(fs_v[2]), .act_bus(bus_c),
        .busy(busy_w[2]), .frame_done(done_w[2]));

    assign bus_a.pix_in = pix_v[0];  assign bus_a.pix_in_valid = valid_v[0];
    assign bus_b.pix_in = pix_v[1];  assign bus_b.pix_in_valid = valid_v[1];
    assign bus_c.pix_in = pix_v[2];  assign bus_c.pix_in_valid = valid_v[2];
    assign act_w[0] = bus_a.stream_act;  assign en_w[0] = bus_a.stream_act_en;  assign ready_w[0] = bus_a.pix_in_ready;
    assign act_w[1] = bus_b.stream_act;  assign en_w[1] = bus_b.stream_act_en;  assign ready_w[1] = bus_b.pix_in_ready;
    assign act_w[2] = bus_c.stream_act;  assign en_w[2] = bus_c.stream_act_en;  assign ready_w[2] = bus_c.pix_in_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, expv, $time);
        end
    endtask

    // Runs one frame on instance sel, starting and ending at a falling edge with the DUT idle.
    //   stall_at/stall_len : hold pix_in_valid low for stall_len data cycles while pixel stall_at is pending
    //   rand_stall         : additionally drop valid at random on data positions
    //   poke_start         : pulse frame_start mid-frame and in the DONE cycle
    //   abort_at           : assert reset once this many elements have been seen (0 = never)
    task automatic run_frame(input int sel, input bit seq_px, input int stall_at, input int stall_len,
                             input bit rand_stall, input bit poke_start, input int abort_at);
        int         p;
        bit         pb;
        int         n;
        int         pos;
        int         pidx;
        int         emitted;
        int         tail;
        int         stalls;
        int         stall_done;
        int         first_en;
        int         last_en;
        int         cyc;
        bit         v;
        bit         adv;
        bit         exp_en;
        bit         exp_busy;
        bit         exp_done;
        logic [3:0] px[$];
        logic [3:0] exp_q[$];
        bit         padf[$];
        logic [3:0] e;

        case (sel)
            0:       begin p = 1; pb = 1'b0; end
            1:       begin p = 1; pb = 1'b1; end
            default: begin p = 0; pb = 1'b0; end
        endcase

        for (int k = 0; k < W * H; k++) begin
            if (seq_px) px.push_back(4'(k + 1));
            else        px.push_back(4'($urandom_range(0, 15)));
        end
        // Reference: padded raster, border elements are pad_bit replicated, interior consumes pixels in order.
        pidx = 0;
        for (int r = 0; r < H + 2 * p; r++) begin
            for (int c = 0; c < W + 2 * p; c++) begin
                if (r < p || r >= H + p || c < p || c >= W + p) begin
                    padf.push_back(1'b1);
                    exp_q.push_back({4{pb}});
                end else begin
                    padf.push_back(1'b0);
                    exp_q.push_back(px[pidx]);
                    pidx++;
                end
            end
        end
        n = padf.size();

        fs_v[sel]    = 1'b1;
        valid_v[sel] = 1'b0;
        @(negedge clk);
        fs_v[sel] = 1'b0;

        pos = 0; pidx = 0; emitted = 0; tail = 0; stalls = 0; stall_done = 0;
        first_en = -1; last_en = -1;
        exp_en = 1'b0; exp_busy = 1'b1; exp_done = 1'b0;

        for (cyc = 0; cyc < 300 && tail < 3; cyc++) begin
            check_value("stream_act_en", en_w[sel], exp_en);
            check_value("busy", busy_w[sel], exp_busy);
            check_value("frame_done", done_w[sel], exp_done);
            if (en_w[sel]) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                emitted++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_value("stream_act", act_w[sel], e);
                end else begin
                    check_value("extra_element", 32'd1, 32'd0);
                end
            end

            if (abort_at > 0 && emitted == abort_at) begin
                reset        = 1'b0;
                valid_v[sel] = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_value("abort_en", en_w[sel], 1'b0);
                    check_value("abort_busy", busy_w[sel], 1'b0);
                    check_value("abort_done", done_w[sel], 1'b0);
                    check_value("abort_ready", ready_w[sel], 1'b0);
                end
                reset        = 1'b1;
                valid_v[sel] = 1'b0;
                return;
            end

            if (pos < n) begin
                check_value("pix_in_ready", ready_w[sel], !padf[pos]);
                v = 1'b1;
                if (!padf[pos]) begin
                    if (pidx == stall_at && stall_done < stall_len) begin
                        v = 1'b0;
                        stall_done++;
                    end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                        v = 1'b0;
                    end
                    if (!v) stalls++;
                end
                fs_v[sel]    = poke_start && (pos == 7);
                valid_v[sel] = v;
                pix_v[sel]   = (pidx < px.size()) ? px[pidx] : 4'h0;
                adv = padf[pos] || v;
                if (adv && !padf[pos]) pidx++;
                if (adv) pos++;
                exp_en = adv; exp_busy = 1'b1; exp_done = 1'b0;
            end else begin
                fs_v[sel]    = poke_start && (tail == 0);
                valid_v[sel] = 1'b0;
                exp_en = 1'b0; exp_busy = 1'b0; exp_done = (tail == 0);
                tail++;
            end
            @(negedge clk);
        end
        fs_v[sel]    = 1'b0;
        valid_v[sel] = 1'b0;

        check_value("frame_timeout", (tail >= 3), 1'b1);
        check_value("element_count", emitted, n);
        check_value("element_span", last_en - first_en + 1, n + stalls);
        check_value("leftover_expected", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fs_v[i] = 1'b1; valid_v[i] = 1'b1; pix_v[i] = 4'hF;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_value("rst_en", en_w[i], 1'b0);
            check_value("rst_act", act_w[i], 4'h0);
            check_value("rst_busy", busy_w[i], 1'b0);
            check_value("rst_done", done_w[i], 1'b0);
            check_value("rst_ready", ready_w[i], 1'b0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fs_v[i] = 1'b0; valid_v[i] = 1'b0; pix_v[i] = 4'h0;
        end
        @(negedge clk);

        run_frame(0, 1'b1, -1, 0, 1'b0, 1'b0, 0);   // plain frame, pixels 1..12
        run_frame(0, 1'b0,  5, 3, 1'b0, 1'b0, 0);   // 3-cycle stall at pixel 6
        run_frame(0, 1'b0, -1, 0, 1'b0, 1'b1, 0);   // stray frame_start pulses
        run_frame(0, 1'b0, -1, 0, 1'b0, 1'b0, 10);  // reset after 10th element
        run_frame(0, 1'b1, -1, 0, 1'b0, 1'b0, 0);   // clean frame after abort
        run_frame(1, 1'b0, -1, 0, 1'b0, 1'b0, 0);   // pad_bit = 1
        run_frame(2, 1'b1, -1, 0, 1'b0, 1'b0, 0);   // pad = 0 passthrough
        for (int i = 0; i < 5; i++) begin
            run_frame(int'($urandom_range(0, 2)), 1'b0, -1, 0, 1'b1, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
